// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - shared unified-memory arbiter/sequencer for fetch and data ports
//
// Purpose: grants one memory access at a time to either the fetch port or
// the data (load/store) port. It runs each access through a fixed-latency
// ACCESS/WAIT/RESP sequence and returns read data or a store acknowledge.
// Optional fetch anti-starvation is compiled in with MEM_PORT_ARB_STARVE_EN.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   hlt                   core halt; blocks new grants only
//   if_req/if_addr        fetch request; if_gnt accept, if_rvalid/if_rdata response
//   dm_req/dm_we/dm_addr/dm_wdata  data request; dm_gnt accept, dm_rvalid/dm_rdata response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  single-port memory interface
//   stall_if, stall_mem   pending-but-not-granted indications for the pipeline
module mem_port_arb #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("mem_port_arb: MEM_LAT must be 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arb: STARVE_MAX must be 1..15");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 1 = data port owns the access
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic [1:0]  lat_q, lat_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        dm_rvalid_q, dm_rvalid_d;

  logic        can_grant;
  logic        promote;
  logic        if_gnt_c;
  logic        dm_gnt_c;

`ifdef MEM_PORT_ARB_STARVE_EN
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  assign promote = (starve_cnt_q == 4'(STARVE_MAX));
`else
  assign promote = 1'b0;
`endif

  // RESP doubles as IDLE so a response and the next grant can share a cycle.
  assign can_grant = ~rst & ~hlt & ((state_q == IDLE) | (state_q == RESP));
  assign dm_gnt_c  = can_grant & dm_req & ~(if_req & promote);
  assign if_gnt_c  = can_grant & if_req & ~dm_gnt_c;

  assign if_gnt    = if_gnt_c;
  assign dm_gnt    = dm_gnt_c;
  assign stall_if  = ~rst & if_req & ~if_gnt_c;
  assign stall_mem = ~rst & dm_req & ~dm_gnt_c;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = resp_q;
  assign dm_rdata  = resp_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    lat_d       = lat_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (if_gnt_c | dm_gnt_c) begin
          state_d  = ACCESS;
          owner_d  = dm_gnt_c;
          we_d     = dm_gnt_c & dm_we;
          addr_d   = dm_gnt_c ? dm_addr : if_addr;
          wdata_d  = dm_gnt_c ? dm_wdata : 32'h0;
          mem_en_d = 1'b1;
          mem_we_d = dm_gnt_c & dm_we;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        lat_d   = 2'(MEM_LAT - 1);
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          state_d     = RESP;
          resp_d      = we_q ? 32'h0 : mem_rdata;
          if_rvalid_d = ~owner_q;
          dm_rvalid_d = owner_q;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_PORT_ARB_STARVE_EN
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_c) begin
      starve_cnt_d = 4'd0;
    end else if (dm_gnt_c & if_req) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_q       <= 32'h0;
      lat_q        <= 2'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
`ifdef MEM_PORT_ARB_STARVE_EN
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_q       <= resp_d;
      lat_q        <= lat_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
`ifdef MEM_PORT_ARB_STARVE_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer that shares the single-port, word-addressed unified memory between the fetch port (instruction reads) and the memory-access port (loads and stores) of the 5-stage core. It grants one access at a time, drives the memory through a fixed-latency access sequence, and returns read data or a write acknowledge to the winning port. It also emits stall signals so the pipeline can freeze the losing stage, and it honours the core halt signal.

## Interface
- MEM_LAT, 1: cycles from the `mem_en` cycle until `mem_rdata` is valid; legal range 1..4.
- STARVE_MAX, 3: number of consecutive data-port grants allowed while fetch waits; legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hlt  in  1  core halted; no new grants while high.
- if_req  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; `if_rdata` is valid.
- if_rdata  out  32  instruction word.
- dm_req  in  1  data request; held with its payload stable until `dm_gnt`.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data word address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledge.
- dm_rdata  out  32  load data; 0 for a store acknowledge.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by `mem_en`.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the `mem_en` cycle.
- stall_if  out  1  `if_req & ~if_gnt`.
- stall_mem  out  1  `dm_req & ~dm_gnt`.

## Operation
- FSM states:
  - IDLE: may grant.
  - ACCESS: `mem_en` is high for one cycle.
  - WAIT: latency counter runs.
  - RESP: response is delivered.
- IDLE:
  - If `hlt` is high, or neither port requests, the FSM stays in IDLE.
  - Otherwise it picks a winner and asserts that port's `*_gnt` combinationally.
  - On the same edge it latches the owner, address, we and wdata, then goes to ACCESS.
- Priority: the data port wins over fetch, because it serves the older instruction.
- Starvation counter (`starve_cnt`, 4 bits):
  - Increments on each data grant made while `if_req` is high.
  - Clears to 0 on any fetch grant.
  - When `starve_cnt == STARVE_MAX`, fetch wins the next arbitration that has both requests.
- ACCESS: `mem_en=1`, with `mem_we`, `mem_addr` and `mem_wdata` taken from the latched values. Next state is WAIT. The latency counter loads MEM_LAT-1.
- WAIT: the counter decrements. When it reaches 0, the FSM captures `mem_rdata` into the response register (or 0 for a store) and goes to RESP. With MEM_LAT=1, WAIT lasts exactly one cycle and the capture happens in it.
- RESP:
  - Pulses the owner's `*_rvalid` with the registered data.
  - Behaves as IDLE in the same cycle: it may grant, and it goes to ACCESS on a grant or to IDLE otherwise.
  - Responses and grants can therefore coincide.
- Exactly one access is in flight at any time. Requests seen in ACCESS or WAIT are not granted and only raise the stall outputs.
- `hlt` does not abort an in-flight access; it completes through RESP. `hlt` only blocks new grants.
- `rst`:
  - Synchronously forces IDLE and zeroes the counters, the latched payload and the response register.
  - An in-flight access is dropped: no `rvalid` is produced and `mem_en` is low from the next cycle.
- Reset values of outputs:
  - All outputs are 0.
  - `if_gnt`, `dm_gnt` and the stall outputs follow their combinational definitions, so they are 0 while `rst` is high.

## Timing
- Grant at cycle t.
- `mem_en` at cycle t+1.
- `mem_rdata` sampled at cycle t+1+MEM_LAT.
- `rvalid` at cycle t+2+MEM_LAT.
- Earliest next grant: cycle t+2+MEM_LAT.
- Throughput: one access per MEM_LAT+2 cycles (3 cycles at MEM_LAT=1).
- `if_gnt`, `dm_gnt`, `stall_if` and `stall_mem` are combinational from the requests, the state and `hlt`.
- All other outputs are registered.

## Configuration
- `MEM_PORT_ARB_STARVE_EN` defined:
  - The starvation counter and the fetch-promotion rule are compiled in.
- Not defined:
  - Strict data priority; `starve_cnt` is absent and STARVE_MAX is ignored.
  - Fetch can starve for as long as `dm_req` stays continuously high.

## Test plan
- Fetch-only read:
  - Stimulus: MEM_LAT=1, memory preloaded with [5]=0xDEADBEEF, `if_req` with `if_addr`=5 at cycle 0.
  - Required: `if_gnt` at cycle 0, `mem_en` with `mem_addr`=5 at cycle 1, `if_rvalid` with `if_rdata`=0xDEADBEEF at cycle 3.
- Store then load:
  - Stimulus: `dm_we`=1, `dm_addr`=9, `dm_wdata`=0x1234.
  - Required: `mem_we`=1 for one cycle and `dm_rvalid` with `dm_rdata`=0. A following load from 9 returns 0x1234.
- Contention:
  - Stimulus: both ports request at cycle 0.
  - Required: `dm_gnt` at cycle 0 with `stall_if`=1; `if_gnt` at cycle 3, the same cycle as `dm_rvalid`.
- Starvation (macro defined, STARVE_MAX=3):
  - Stimulus: `dm_req` and `if_req` held high continuously.
  - Required: grant sequence D, D, D, F, D, D, D, F.
  - Without the macro: D forever and `if_gnt` never rises.
- Halt and reset:
  - Stimulus A: `hlt` raised in the `mem_en` cycle.
  - Required A: the access completes with `rvalid`, and no further grant occurs while `hlt`=1.
  - Stimulus B: `rst` raised during WAIT with MEM_LAT=3.
  - Required B: no `rvalid`, all outputs 0 on the next cycle, and a new request is granted normally after `rst` falls.
